cdc_sync_fifo_frontend: RTL and testbench

- Single-clock receive front end for an asynchronous serial interface; bundles three independent sub-functions behind one port list.
- Strobe synchronizer: 2-FF synchronizer with rising/falling edge pulses.
- Level synchronizer: 2-FF synchronizer with a parameterized reset value.
- FIFO: synchronous first-word-fall-through-free FIFO with registered read data and a fill count; buffers sequential read data for the serial side.

---
 rtl/cdc_sync_fifo_frontend_if.sv | 38 +++
 rtl/cdc_sync_fifo_frontend.sv | 161 ++++++++++++++++
 tb/tb_cdc_sync_fifo_frontend.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_sync_fifo_frontend_if.sv
// -----------------------------------------------------------------------------
// cdc_sync_fifo_frontend_if
// Groups the FIFO side of the receive front end into one bundle.
//   flush_i    : synchronous FIFO clear (driven by master)
//   wr_i       : write request           (driven by master)
//   wr_data_i  : write data, WIDTH bits  (driven by master)
//   rd_i       : read request            (driven by master)
//   rd_data_o  : registered read data    (driven by slave / FIFO)
//   full_o     : FIFO full               (driven by slave / FIFO)
//   empty_o    : FIFO empty              (driven by slave / FIFO)
//   filled_o   : occupancy 0..DEPTH      (driven by slave / FIFO)
// WIDTH and DEPTH must match the parameters of the attached front end.
// -----------------------------------------------------------------------------
interface cdc_sync_fifo_frontend_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             flush_i;
    logic             wr_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             rd_i;
    logic [WIDTH-1:0] rd_data_o;
    logic             full_o;
    logic             empty_o;
    logic [CW-1:0]    filled_o;

    modport master (
        output flush_i, wr_i, wr_data_i, rd_i,
        input  rd_data_o, full_o, empty_o, filled_o
    );

    modport slave (
        input  flush_i, wr_i, wr_data_i, rd_i,
        output rd_data_o, full_o, empty_o, filled_o
    );
endinterface

// File: rtl/cdc_sync_fifo_frontend.sv
// -----------------------------------------------------------------------------
// cdc_sync_fifo_frontend
// Single-clock receive front end for an asynchronous serial interface.
// Three independent functions share one clock and one reset:
//   * strobe synchronizer : stb_i -> stb_q_o plus one-cycle edge pulses
//                           stb_pe_o (rising) and stb_ne_o (falling)
//   * level synchronizer  : lvl_i -> lvl_q_o, both stages reset to LVL_RESET
//   * FIFO                : DEPTH x WIDTH circular buffer with registered read
//                           data and a registered fill count (fifo bundle)
// Ports:
//   clk_i    : system clock, all state on the rising edge
//   reset_i  : synchronous active-high reset of the whole block
//   stb_i, stb_q_o, stb_pe_o, stb_ne_o : strobe synchronizer
//   lvl_i, lvl_q_o                     : level synchronizer
//   fifo     : FIFO handshake bundle (slave side)
// -----------------------------------------------------------------------------
module cdc_sync_fifo_frontend #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 16,
    parameter logic        LVL_RESET = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,

    input  logic stb_i,
    output logic stb_q_o,
    output logic stb_pe_o,
    output logic stb_ne_o,

    input  logic lvl_i,
    output logic lvl_q_o,

    cdc_sync_fifo_frontend_if.slave fifo
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // -------------------------------------------------------------------------
    // Strobe synchronizer: bits [1:0] are the metastability chain, bit 2 is the
    // previous synchronized value used only for edge detection.
    // -------------------------------------------------------------------------
    logic [2:0] stb_sync_q;
    logic [2:0] stb_sync_d;

    always_comb begin
        stb_sync_d = {stb_sync_q[1:0], stb_i};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stb_sync_q <= 3'b000;
        end else begin
            stb_sync_q <= stb_sync_d;
        end
    end

    assign stb_q_o  = stb_sync_q[1];
    assign stb_pe_o =  stb_sync_q[1] & ~stb_sync_q[2];
    assign stb_ne_o = ~stb_sync_q[1] &  stb_sync_q[2];

    // -------------------------------------------------------------------------
    // Level synchronizer
    // -------------------------------------------------------------------------
    logic [1:0] lvl_sync_q;
    logic [1:0] lvl_sync_d;

    always_comb begin
        lvl_sync_d = {lvl_sync_q[0], lvl_i};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lvl_sync_q <= {2{LVL_RESET}};
        end else begin
            lvl_sync_q <= lvl_sync_d;
        end
    end

    assign lvl_q_o = lvl_sync_q[1];

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wptr_q,    wptr_d;
    logic [AW-1:0]    rptr_q,    rptr_d;
    logic [CW-1:0]    filled_q,  filled_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;

    assign full  = (filled_q == FULL_CNT);
    assign empty = (filled_q == '0);

    always_comb begin
        // Flags come from the registered count, so a write on a full FIFO is
        // refused even when a read frees a slot in the same cycle, and a read
        // on an empty FIFO is refused even when a write arrives alongside it.
        // Reset and flush also block the memory write so a clear never leaves
        // a stray word behind the zeroed pointers.
        wr_acc = fifo.wr_i & ~full & ~fifo.flush_i & ~reset_i;
        rd_acc = fifo.rd_i & ~empty;

        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        filled_d  = filled_q;
        rd_data_d = rd_data_q;

        if (fifo.flush_i) begin
            wptr_d    = '0;
            rptr_d    = '0;
            filled_d  = '0;
            rd_data_d = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (rd_acc) begin
                rptr_d    = rptr_q + AW'(1);
                rd_data_d = mem[rptr_q];
            end
            case ({wr_acc, rd_acc})
                2'b10:   filled_d = filled_q + CW'(1);
                2'b01:   filled_d = filled_q - CW'(1);
                default: filled_d = filled_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            filled_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            filled_q  <= filled_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage has no reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wptr_q] <= fifo.wr_data_i;
        end
    end

    assign fifo.rd_data_o = rd_data_q;
    assign fifo.full_o    = full;
    assign fifo.empty_o   = empty;
    assign fifo.filled_o  = filled_q;

endmodule

// File: tb/tb_cdc_sync_fifo_frontend.sv
// -----------------------------------------------------------------------------
// tb_cdc_sync_fifo_frontend
// Self-checking bench for cdc_sync_fifo_frontend (WIDTH=16, DEPTH=16,
// LVL_RESET=1). Every clock cycle is one transaction: inputs are applied,
// the reference model advances at the edge, and all outputs are compared 1
// time unit later. The reference model keeps the FIFO as a queue and the
// synchronizers as the history of values sampled at recent clock edges.
// -----------------------------------------------------------------------------
module tb_cdc_sync_fifo_frontend;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic clk_i = 1'b0;
    logic reset_i;
    logic stb_i;
    logic stb_q_o;
    logic stb_pe_o;
    logic stb_ne_o;
    logic lvl_i;
    logic lvl_q_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cdc_sync_fifo_frontend_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    cdc_sync_fifo_frontend #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .LVL_RESET(1'b1)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .stb_i    (stb_i),
        .stb_q_o  (stb_q_o),
        .stb_pe_o (stb_pe_o),
        .stb_ne_o (stb_ne_o),
        .lvl_i    (lvl_i),
        .lvl_q_o  (lvl_q_o),
        .fifo     (bus)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model state ----------------
    logic [WIDTH-1:0] m_q [$];   // FIFO contents, oldest first
    logic [WIDTH-1:0] m_rd;      // last popped word
    logic             stb_s [3]; // stb_i sampled at edge k, k-1, k-2
    logic             lvl_s [2]; // lvl_i sampled at edge k, k-1

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock transaction with full model comparison.
    task automatic cycle(input logic rst, input logic s, input logic l, input logic fl,
                         input logic w, input logic [WIDTH-1:0] wd, input logic r);
        bit m_full;
        bit m_empty;
        reset_i       = rst;
        stb_i         = s;
        lvl_i         = l;
        bus.flush_i   = fl;
        bus.wr_i      = w;
        bus.wr_data_i = wd;
        bus.rd_i      = r;
        @(posedge clk_i);
        cyc++;
        if (rst) begin
            m_q.delete();
            m_rd = '0;
            for (int i = 0; i < 3; i++) stb_s[i] = 1'b0;
            for (int i = 0; i < 2; i++) lvl_s[i] = 1'b1;
        end else begin
            stb_s[2] = stb_s[1];
            stb_s[1] = stb_s[0];
            stb_s[0] = s;
            lvl_s[1] = lvl_s[0];
            lvl_s[0] = l;
            if (fl) begin
                m_q.delete();
                m_rd = '0;
            end else begin
                m_full  = (m_q.size() == DEPTH);
                m_empty = (m_q.size() == 0);
                if (r && !m_empty) m_rd = m_q.pop_front();
                if (w && !m_full)  m_q.push_back(wd);
            end
        end
        #1;
        check("model_stb_q",  32'(stb_q_o),  32'(stb_s[1]));
        check("model_stb_pe", 32'(stb_pe_o), 32'(stb_s[1] & ~stb_s[2]));
        check("model_stb_ne", 32'(stb_ne_o), 32'(~stb_s[1] & stb_s[2]));
        check("model_lvl_q",  32'(lvl_q_o),  32'(lvl_s[1]));
        check("model_rd",     32'(bus.rd_data_o), 32'(m_rd));
        check("model_filled", 32'(bus.filled_o),  32'(m_q.size()));
        check("model_empty",  32'(bus.empty_o),   32'(m_q.size() == 0));
        check("model_full",   32'(bus.full_o),    32'(m_q.size() == DEPTH));
        $display("cyc %0d rst=%b stb=%b lvl=%b fl=%b wr=%b wd=%h rd=%b | stbq=%b pe=%b ne=%b lvlq=%b rdata=%h filled=%0d e=%b f=%b",
                 cyc, rst, s, l, fl, w, wd, r, stb_q_o, stb_pe_o, stb_ne_o, lvl_q_o,
                 bus.rd_data_o, bus.filled_o, bus.empty_o, bus.full_o);
    endtask

    typedef struct {
        logic             rst, stb, lvl, fl, wr;
        logic [WIDTH-1:0] wd;
        logic             rd;
        logic             e_stbq, e_pe, e_ne, e_lvlq;
        logic [WIDTH-1:0] e_rd;
        logic [4:0]       e_filled;
        logic             e_empty, e_full;
    } vec_t;

    vec_t vt [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] v [23];
        logic cur_stb;
        logic cur_lvl;
        logic r_rst, r_fl, r_wr, r_rd;

        // Reset, strobe rise/fall, level fall/rise, empty-FIFO corner cases.
        //          rst  stb  lvl  fl   wr   wd        rd  | stbq pe   ne   lvlq rd       fill  e    f
        vt[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b1,16'h0000,5'd0,1'b1,1'b0};
        vt[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b1,16'h0000,5'd0,1'b1,1'b0};
        vt[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b1,1'b0,1'b0,16'h0000,5'd0,1'b1,1'b0};
        vt[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,16'h0000,5'd0,1'b1,1'b0};
        vt[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,16'h0000,5'd0,1'b1,1'b0};
        vt[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,16'h0000,5'd0,1'b1,1'b0};
        vt[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,16'h0000,5'd0,1'b1,1'b0};
        vt[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b1,16'h0000,5'd0,1'b1,1'b0};
        vt[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,16'h1234,1'b1, 1'b0,1'b0,1'b0,1'b1,16'h0000,5'd1,1'b0,1'b0};
        vt[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,1'b0,1'b1,16'h1234,5'd0,1'b1,1'b0};
        vt[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,1'b0,1'b1,16'h1234,5'd0,1'b1,1'b0};

        reset_i = 1'b1; stb_i = 1'b0; lvl_i = 1'b0;
        bus.flush_i = 1'b0; bus.wr_i = 1'b0; bus.wr_data_i = '0; bus.rd_i = 1'b0;

        for (int i = 0; i < 11; i++) begin
            cycle(vt[i].rst, vt[i].stb, vt[i].lvl, vt[i].fl, vt[i].wr, vt[i].wd, vt[i].rd);
            check("vec_stb_q",  32'(stb_q_o),  32'(vt[i].e_stbq));
            check("vec_stb_pe", 32'(stb_pe_o), 32'(vt[i].e_pe));
            check("vec_stb_ne", 32'(stb_ne_o), 32'(vt[i].e_ne));
            check("vec_lvl_q",  32'(lvl_q_o),  32'(vt[i].e_lvlq));
            check("vec_rd",     32'(bus.rd_data_o), 32'(vt[i].e_rd));
            check("vec_filled", 32'(bus.filled_o),  32'(vt[i].e_filled));
            check("vec_empty",  32'(bus.empty_o),   32'(vt[i].e_empty));
            check("vec_full",   32'(bus.full_o),    32'(vt[i].e_full));
        end

        // Fill to full, refused 17th write, drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'(i + 1), 1'b0);
        check("fill_full",   32'(bus.full_o),   32'd1);
        check("fill_filled", 32'(bus.filled_o), 32'd16);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        check("overflow_filled", 32'(bus.filled_o), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
            check("drain_data", 32'(bus.rd_data_o), 32'(i + 1));
        end
        check("drain_empty", 32'(bus.empty_o), 32'd1);

        // Three entries, then 20 simultaneous read/write cycles across the wrap.
        for (int i = 0; i < 23; i++) v[i] = 16'hA000 + 16'(i * 7);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, v[i], 1'b0);
        for (int j = 0; j < 20; j++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, v[j + 3], 1'b1);
            check("rw_data",   32'(bus.rd_data_o), 32'(v[j]));
            check("rw_filled", 32'(bus.filled_o),  32'd3);
        end

        // Flush with 5 entries and a write pending; synchronizers hold.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5555, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h6666, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("preflush_filled", 32'(bus.filled_o), 32'd5);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h7777, 1'b1);
        check("flush_filled", 32'(bus.filled_o),  32'd0);
        check("flush_empty",  32'(bus.empty_o),   32'd1);
        check("flush_rd",     32'(bus.rd_data_o), 32'd0);
        check("flush_stb_q",  32'(stb_q_o),       32'd1);
        check("flush_lvl_q",  32'(lvl_q_o),       32'd1);

        // Randomized traffic against the model, alternating fill- and
        // drain-biased phases so both full and empty are reached.
        cur_stb = 1'b1;
        cur_lvl = 1'b1;
        for (int n = 0; n < 400; n++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_fl  = ($urandom_range(0, 39) == 0);
            if (((n / 50) % 2) == 0) begin
                r_wr = ($urandom_range(0, 9) < 8);
                r_rd = ($urandom_range(0, 9) < 3);
            end else begin
                r_wr = ($urandom_range(0, 9) < 3);
                r_rd = ($urandom_range(0, 9) < 8);
            end
            if ($urandom_range(0, 3) == 0) cur_stb = ~cur_stb;
            if ($urandom_range(0, 5) == 0) cur_lvl = ~cur_lvl;
            cycle(r_rst, cur_stb, cur_lvl, r_fl, r_wr, 16'($urandom), r_rd);
        end

        // Mid-operation reset with every other input active.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hC000 + 16'(i), 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b1);
        check("mrst_filled", 32'(bus.filled_o),  32'd0);
        check("mrst_empty",  32'(bus.empty_o),   32'd1);
        check("mrst_rd",     32'(bus.rd_data_o), 32'd0);
        check("mrst_stb_q",  32'(stb_q_o),       32'd0);
        check("mrst_lvl_q",  32'(lvl_q_o),       32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
